// File: rtl/pixel_write_arbiter.sv
// pixel_write_arbiter: owns the single write port of the 1-bit pixel frame
// memory. Two plot requesters share it round-robin, and a clear sweep can
// blank the plot region. No traffic is issued until the memory reports that
// its own initialisation has completed.
module pixel_write_arbiter #(
  parameter int PLOT_W = 480,
  parameter int PLOT_H = 480
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_ready,
  input  logic        req0_valid,
  input  logic [8:0]  req0_x,
  input  logic [8:0]  req0_y,
  input  logic        req0_color,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [8:0]  req1_x,
  input  logic [8:0]  req1_y,
  input  logic        req1_color,
  output logic        req1_ready,
  input  logic        clear_req,
  output logic        clear_busy,
  output logic        clear_done,
  output logic [8:0]  wr_x,
  output logic [8:0]  wr_y,
  output logic        wr_color,
  output logic        wr_en,
  output logic [15:0] drop_count
);

  typedef enum logic [1:0] {WAIT_MEM, SERVE, CLEAR} state_t;

  state_t      state_q, state_d;
  logic        pend_q, pend_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        last_q, last_d;      // 1: requester 1 was granted last
  logic [8:0]  clr_x_q, clr_x_d;
  logic [8:0]  clr_y_q, clr_y_d;
  logic [8:0]  wr_x_q, wr_x_d;
  logic [8:0]  wr_y_q, wr_y_d;
  logic        wr_color_q, wr_color_d;
  logic        wr_en_q, wr_en_d;
  logic [15:0] drop_q, drop_d;

  logic        can_acc;
  logic        grant1;
  logic [8:0]  sel_x;
  logic [8:0]  sel_y;
  logic        sel_c;
  logic        in_range;

  // Next-state, grant selection and write-port outputs
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    last_d     = last_q;
    clr_x_d    = clr_x_q;
    clr_y_d    = clr_y_q;
    wr_x_d     = wr_x_q;
    wr_y_d     = wr_y_q;
    wr_color_d = wr_color_q;
    wr_en_d    = 1'b0;
    drop_d     = drop_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;

    // Requester 1 wins when alone, or when both ask and requester 0 went last.
    grant1   = req1_valid && (!req0_valid || !last_q);
    sel_x    = grant1 ? req1_x : req0_x;
    sel_y    = grant1 ? req1_y : req0_y;
    sel_c    = grant1 ? req1_color : req0_color;
    in_range = ({1'b0, sel_x} < 10'(PLOT_W)) && ({1'b0, sel_y} < 10'(PLOT_H));
    // busy_q still high in SERVE means this is the clear_done cycle: hold off.
    can_acc  = (state_q == SERVE) && mem_ready && !clear_req && !pend_q && !busy_q;

    unique case (state_q)
      WAIT_MEM: begin
        if (clear_req) pend_d = 1'b1;
        busy_d  = pend_q || clear_req;
        clr_x_d = '0;
        clr_y_d = '0;
        if (mem_ready) state_d = (pend_q || clear_req) ? CLEAR : SERVE;
      end
      SERVE: begin
        busy_d  = 1'b0;
        clr_x_d = '0;
        clr_y_d = '0;
        if (!mem_ready) begin
          state_d = WAIT_MEM;
          pend_d  = clear_req;
          busy_d  = clear_req;
        end else if (clear_req) begin
          state_d = CLEAR;
          busy_d  = 1'b1;
        end else if (can_acc && (req0_valid || req1_valid)) begin
          req0_ready = !grant1;
          req1_ready = grant1;
          last_d     = grant1;
          if (in_range) begin
            wr_en_d    = 1'b1;
            wr_x_d     = sel_x;
            wr_y_d     = sel_y;
            wr_color_d = sel_c;
          end else if (drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
          end
        end
      end
      CLEAR: begin
        if (!mem_ready) begin
          // The memory's own init blanks the frame, so the sweep is dropped.
          state_d = WAIT_MEM;
          pend_d  = 1'b0;
          busy_d  = 1'b0;
        end else begin
          wr_en_d    = 1'b1;
          wr_x_d     = clr_x_q;
          wr_y_d     = clr_y_q;
          wr_color_d = 1'b0;
          busy_d     = 1'b1;
          if ((clr_x_q == 9'(PLOT_W - 1)) && (clr_y_q == 9'(PLOT_H - 1))) begin
            done_d  = 1'b1;
            state_d = SERVE;
            pend_d  = 1'b0;
          end else if (clr_x_q == 9'(PLOT_W - 1)) begin
            clr_x_d = '0;
            clr_y_d = clr_y_q + 9'd1;
          end else begin
            clr_x_d = clr_x_q + 9'd1;
          end
        end
      end
      default: state_d = WAIT_MEM;
    endcase
  end

  // State and registered write-port outputs, cleared asynchronously
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= WAIT_MEM;
      pend_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      last_q     <= 1'b1;
      clr_x_q    <= '0;
      clr_y_q    <= '0;
      wr_x_q     <= '0;
      wr_y_q     <= '0;
      wr_color_q <= 1'b0;
      wr_en_q    <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      last_q     <= last_d;
      clr_x_q    <= clr_x_d;
      clr_y_q    <= clr_y_d;
      wr_x_q     <= wr_x_d;
      wr_y_q     <= wr_y_d;
      wr_color_q <= wr_color_d;
      wr_en_q    <= wr_en_d;
      drop_q     <= drop_d;
    end
  end

  assign clear_busy = busy_q;
  assign clear_done = done_q;
  assign wr_x       = wr_x_q;
  assign wr_y       = wr_y_q;
  assign wr_color   = wr_color_q;
  assign wr_en      = wr_en_q;
  assign drop_count = drop_q;

endmodule

// File: doc/pixel_write_arbiter.md
Name: pixel_write_arbiter

Overview:
- Schedules the single write port of the 1-bit pixel frame memory.
- Arbitrates round-robin between two plot requesters (point plotters of the Pi estimator) and runs a clear sweep that blanks the plot region on command.
- Holds off all traffic until the memory's power-on initialisation completes.
- Sits between the estimator logic and the pixel memory write inputs (writeX/writeY/wrEnable/din).

Parameters:
PLOT_W, 480, plot region width in pixels (1..512); valid x range 0..PLOT_W-1
PLOT_H, 480, plot region height in pixels (1..512); valid y range 0..PLOT_H-1

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
mem_ready  input  1  pixel memory initialisation done (its reset_done)
req0_valid  input  1  requester 0 has a pixel to write
req0_x  input  9  requester 0 x coordinate
req0_y  input  9  requester 0 y coordinate
req0_color  input  1  requester 0 pixel value
req0_ready  output  1  requester 0 accepted this cycle (valid & ready)
req1_valid / req1_x / req1_y / req1_color / req1_ready  same as requester 0, for requester 1
clear_req  input  1  single-cycle pulse: blank the plot region
clear_busy  output  1  clear sweep in progress or pending
clear_done  output  1  one-cycle pulse at end of sweep
wr_x  output  9  memory write x
wr_y  output  9  memory write y
wr_color  output  1  memory write data
wr_en  output  1  memory write strobe
drop_count  output  16  out-of-range requests discarded, saturating

Behaviour:
- Reset (resetn low, asynchronous): state WAIT_MEM; wr_en=0, wr_x=0, wr_y=0, wr_color=0; req0_ready=req1_ready=0; clear_busy=0, clear_done=0; drop_count=0; round-robin pointer favours requester 0; clear pending flag cleared.
- States: WAIT_MEM, SERVE, CLEAR.
- WAIT_MEM:
  - Both readies held 0.
  - A clear_req pulse sets the pending flag; clear_busy=1 from the next cycle.
  - When mem_ready=1: go to CLEAR if pending, else SERVE.
- SERVE:
  - req*_ready are combinational: asserted only for the granted requester, and only when clear_req=0 and no clear is pending.
  - Grant with one valid requester: that requester.
  - Grant with both valid: the requester not granted last. The pointer updates only on an accepted transfer.
  - At most one acceptance per cycle.
  - Accepted in-range request: wr_x/wr_y/wr_color/wr_en=1 registered on the next clk edge. Fixed one-cycle latency; full throughput, one write per cycle.
  - Accepted out-of-range request (x>=PLOT_W or y>=PLOT_H): consumed, no write, drop_count+1, saturating at 16'hFFFF.
  - wr_en=0 in any cycle with no accepted in-range request. wr_x/wr_y/wr_color hold their last values.
  - clear_req in SERVE: blocks acceptance that same cycle; next state CLEAR.
- CLEAR:
  - Sweeps x=0..PLOT_W-1 inner loop, y=0..PLOT_H-1 outer loop, one pixel per cycle, with wr_en=1 and wr_color=0.
  - First write appears one cycle after entering CLEAR. The sweep lasts exactly PLOT_W*PLOT_H cycles.
  - Both readies are 0 throughout. clear_busy=1 from the cycle after clear_req until the cycle clear_done pulses, inclusive.
  - clear_done=1 for one cycle, coincident with the last write (x=PLOT_W-1, y=PLOT_H-1).
  - Next state is SERVE; the pending flag clears.
  - clear_req during CLEAR is ignored; no restart and no queued second clear.
- mem_ready dropping to 0 in SERVE or CLEAR:
  - Abort any sweep and return to WAIT_MEM; wr_en=0 from the next cycle.
  - An aborted sweep is not resumed and clear_done does not pulse. The memory's own init blanks the frame.
- resetn asserted mid-sweep or mid-transfer: outputs go to reset values immediately; no further writes are issued.
- A requester must hold valid, x, y and color stable until it sees ready; the arbiter does not buffer.

Test Plan:
- Reset and init: resetn low for 3 cycles, mem_ready low 10 cycles, req0_valid=1 (x=5,y=7,c=1) -> req0_ready=0 and wr_en=0 while mem_ready=0. Cycle after mem_ready=1: req0_ready=1. Following cycle: wr_en=1, wr_x=5, wr_y=7, wr_color=1.
- Round-robin: req0 and req1 both valid continuously for 6 cycles -> grants alternate 0,1,0,1,0,1. wr_en high 6 consecutive cycles with matching coordinates, each one cycle after acceptance.
- Out of range: req1 x=480,y=0 then x=0,y=480 -> both accepted, wr_en stays 0, drop_count 0->1->2. In-range req0 in the next cycle writes normally.
- Clear: PLOT_W=4, PLOT_H=3, clear_req pulse with req0_valid held -> 12 writes of color 0 in order (0,0),(1,0)..(3,2); clear_done coincides with (3,2); req0_ready stays 0 until the cycle after clear_done.
- Clear during init: clear_req while mem_ready=0 -> clear_busy=1, sweep starts when mem_ready rises. Second clear_req mid-sweep -> no extra sweep, exactly one clear_done.
- Async reset mid-sweep: resetn low at write 5 of 12 -> wr_en=0 and clear_busy=0 immediately. After release with mem_ready=1: SERVE, no residual writes, no clear_done.
